// File: rtl/wb_sdr_traffic_gen_if.sv
// Wishbone master-side bus bundle for the SDR traffic generator.
interface wb_sdr_traffic_gen_if #(
  parameter int DW = 32,
  parameter int AW = 26
);
  logic            wb_cyc_o;
  logic            wb_stb_o;
  logic            wb_we_o;
  logic [AW-1:0]   wb_addr_o;
  logic [DW-1:0]   wb_dat_o;
  logic [DW/8-1:0] wb_sel_o;
  logic [2:0]      wb_cti_o;
  logic            wb_ack_i;
  logic [DW-1:0]   wb_dat_i;

  modport master (output wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o,
                  input  wb_ack_i, wb_dat_i);
  modport slave  (input  wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o,
                  output wb_ack_i, wb_dat_i);
endinterface

// File: rtl/wb_sdr_traffic_gen.sv
// Self-checking Wishbone burst master: write pattern burst, read back, compare, advance.
// Optional ack watchdog enabled by defining TG_TIMEOUT_EN.
module wb_sdr_traffic_gen #(
  parameter int DW          = 32,
  parameter int AW          = 26,
  parameter int BLW         = 5,
  parameter int NBW         = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                 sys_clk,
  input  logic                 RESETN,
  input  logic                 start,
  input  logic [AW-1:0]        cfg_base_addr,
  input  logic [BLW-1:0]       cfg_burst_len,
  input  logic [NBW-1:0]       cfg_num_bursts,
  input  logic [1:0]           cfg_mode,
  input  logic [31:0]          cfg_seed,
  wb_sdr_traffic_gen_if.master wb,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          err_cnt,
  output logic [AW-1:0]        first_err_addr,
  output logic                 timeout
);
  localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, WR = 3'd2, GAP = 3'd3,
                         RD   = 3'd4, NEXT = 3'd5, FIN = 3'd6;
  localparam logic [AW-1:0] STEP = AW'(DW/8);

  if ((DW != 16 && DW != 32 && DW != 64) || TIMEOUT_CYC < 2) begin : g_bad_param
    $error("wb_sdr_traffic_gen: unsupported DW or TIMEOUT_CYC");
  end

  logic [2:0]     state_q, state_d;
  logic [AW-1:0]  base_q, base_d, addr_q, addr_d, first_q, first_d;
  logic [BLW-1:0] len_q, len_d, beat_q, beat_d;
  logic [NBW-1:0] rem_q, rem_d;
  logic [1:0]     mode_q, mode_d;
  logic [31:0]    pat_q, pat_d, pat0_q, pat0_d;
  logic [15:0]    err_q, err_d;

  logic        stb, last;
  logic [31:0] word, seed_eff;
  logic [DW-1:0] pat_dw;

  function automatic logic [31:0] lfsr_nx(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  always_comb begin
    unique case (mode_q)
      2'd0, 2'd1: word = pat_q;
      2'd2:       word = 32'(addr_q);
      default:    word = ~32'(addr_q);
    endcase
  end

  // Pattern word is replicated across wide buses, truncated on 16-bit ones.
  if (DW >= 32) begin : g_rep
    assign pat_dw = {(DW/32){word}};
  end else begin : g_trunc
    assign pat_dw = word[DW-1:0];
  end

  assign seed_eff = (cfg_mode == 2'd1 && cfg_seed == 32'd0) ? 32'd1 : cfg_seed;
  assign stb      = (state_q == WR) || (state_q == RD);
  assign last     = (beat_q == len_q - 1'b1);

  assign wb.wb_cyc_o  = stb;
  assign wb.wb_stb_o  = stb;
  assign wb.wb_we_o   = (state_q == WR);
  assign wb.wb_addr_o = addr_q;
  assign wb.wb_dat_o  = (state_q == WR) ? pat_dw : '0;
  assign wb.wb_sel_o  = '1;
  assign wb.wb_cti_o  = !stb ? 3'b000 : (last ? 3'b111 : 3'b010);

  assign busy           = (state_q != IDLE) && (state_q != FIN);
  assign done           = (state_q == FIN);
  assign err_cnt        = err_q;
  assign first_err_addr = first_q;

`ifdef TG_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYC + 1);
  logic [WDW-1:0] wd_q, wd_d;
  logic           to_q, to_d;
  assign timeout = to_q;
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;  base_d = base_q;  addr_d = addr_q;  first_d = first_q;
    len_d   = len_q;    beat_d = beat_q;  rem_d  = rem_q;   mode_d  = mode_q;
    pat_d   = pat_q;    pat0_d = pat0_q;  err_d  = err_q;
`ifdef TG_TIMEOUT_EN
    wd_d = '0;
    to_d = to_q;
`endif
    unique case (state_q)
      IDLE: if (start) state_d = LOAD;
      LOAD: begin
        base_d  = cfg_base_addr & ~(STEP - 1'b1);
        addr_d  = cfg_base_addr & ~(STEP - 1'b1);
        len_d   = (cfg_burst_len == '0) ? BLW'(1) : cfg_burst_len;
        rem_d   = cfg_num_bursts;
        mode_d  = cfg_mode;
        pat_d   = seed_eff;
        pat0_d  = seed_eff;
        beat_d  = '0;
        err_d   = '0;
        first_d = '0;
`ifdef TG_TIMEOUT_EN
        to_d    = 1'b0;
`endif
        state_d = (cfg_num_bursts == '0) ? FIN : WR;
      end
      WR, RD: if (wb.wb_ack_i) begin
        if (state_q == RD && wb.wb_dat_i != pat_dw) begin
          if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
          if (err_q == 16'd0)    first_d = addr_q;
        end
        beat_d = beat_q + 1'b1;
        addr_d = addr_q + STEP;
        pat_d  = (mode_q == 2'd1) ? lfsr_nx(pat_q) : pat_q + 32'd1;
        if (last) begin
          beat_d  = '0;
          state_d = (state_q == WR) ? GAP : NEXT;
        end
      end
      // Rewind so the read pass regenerates exactly what was written.
      GAP: begin
        addr_d  = base_q;
        pat_d   = pat0_q;
        state_d = RD;
      end
      // addr_q already sits at base + len*bytes, wrapping modulo 2^AW.
      NEXT: begin
        base_d  = addr_q;
        pat0_d  = pat_q;
        rem_d   = rem_q - 1'b1;
        state_d = (rem_q == NBW'(1)) ? FIN : WR;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef TG_TIMEOUT_EN
    if (stb && !wb.wb_ack_i) begin
      if (wd_q == WDW'(TIMEOUT_CYC - 1)) begin
        to_d    = 1'b1;
        state_d = FIN;
      end else begin
        wd_d = wd_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge sys_clk or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= IDLE;  base_q <= '0;  addr_q <= '0;  first_q <= '0;
      len_q   <= '0;    beat_q <= '0;  rem_q  <= '0;  mode_q  <= '0;
      pat_q   <= '0;    pat0_q <= '0;  err_q  <= '0;
`ifdef TG_TIMEOUT_EN
      wd_q <= '0;
      to_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;  base_q <= base_d;  addr_q <= addr_d;  first_q <= first_d;
      len_q   <= len_d;    beat_q <= beat_d;  rem_q  <= rem_d;   mode_q  <= mode_d;
      pat_q   <= pat_d;    pat0_q <= pat0_d;  err_q  <= err_d;
`ifdef TG_TIMEOUT_EN
      wd_q <= wd_d;
      to_q <= to_d;
`endif
    end
  end
endmodule

// File: tb/tb_wb_sdr_traffic_gen.sv
// Bench for wb_sdr_traffic_gen: random-latency memory slave plus burst-list reference model.
`timescale 1ns/1ps
module tb_wb_sdr_traffic_gen;
  localparam int DW = 32, AW = 26, BLW = 5, NBW = 16, TOC = 16;
  typedef logic [3+AW+DW-1:0] ent_t;  // {cti, addr, data}

  logic sys_clk = 1'b0, RESETN = 1'b0, start = 1'b0;
  logic [AW-1:0]  cfg_base_addr = '0;
  logic [BLW-1:0] cfg_burst_len = '0;
  logic [NBW-1:0] cfg_num_bursts = '0;
  logic [1:0]     cfg_mode = '0;
  logic [31:0]    cfg_seed = '0;
  logic busy, done, timeout;
  logic [15:0] err_cnt;
  logic [AW-1:0] first_err_addr;
  int n_tests = 0, n_fail = 0;

  wb_sdr_traffic_gen_if #(.DW(DW), .AW(AW)) wb();

  wb_sdr_traffic_gen #(.DW(DW), .AW(AW), .BLW(BLW), .NBW(NBW), .TIMEOUT_CYC(TOC)) dut (
    .sys_clk(sys_clk), .RESETN(RESETN), .start(start), .cfg_base_addr(cfg_base_addr),
    .cfg_burst_len(cfg_burst_len), .cfg_num_bursts(cfg_num_bursts), .cfg_mode(cfg_mode),
    .cfg_seed(cfg_seed), .wb(wb), .busy(busy), .done(done), .err_cnt(err_cnt),
    .first_err_addr(first_err_addr), .timeout(timeout));

  always #5 sys_clk = ~sys_clk;

  // Memory slave: acks with random latency, records every accepted beat.
  logic [DW-1:0] mem [logic [AW-1:0]];
  bit corrupt [logic [AW-1:0]];
  bit ack_en = 1'b1;
  ent_t wr_log[$], rd_log[$], exp_log[$];
  int stb_cyc = 0;

  initial begin wb.wb_ack_i = 1'b0; wb.wb_dat_i = '0; end

  always @(negedge sys_clk) begin
    logic [DW-1:0] d;
    wb.wb_ack_i = 1'b0;
    wb.wb_dat_i = '0;
    if (wb.wb_stb_o) stb_cyc++;
    if (wb.wb_stb_o && wb.wb_cyc_o && ack_en && $urandom_range(0, 3) != 0) begin
      wb.wb_ack_i = 1'b1;
      if (wb.wb_we_o) begin
        mem[wb.wb_addr_o] = wb.wb_dat_o;
        wr_log.push_back({wb.wb_cti_o, wb.wb_addr_o, wb.wb_dat_o});
      end else begin
        d = mem.exists(wb.wb_addr_o) ? mem[wb.wb_addr_o] : '0;
        rd_log.push_back({wb.wb_cti_o, wb.wb_addr_o, d});
        if (corrupt.exists(wb.wb_addr_o)) d[0] = ~d[0];
        wb.wb_dat_i = d;
      end
    end
  end

  // Reference model: expected beat list, error count and first error address.
  int exp_err;
  logic [AW-1:0] exp_first;

  function automatic logic [31:0] exp_word(logic [1:0] m, logic [31:0] seed, logic [AW-1:0] a, int n);
    logic [31:0] s;
    case (m)
      2'd0: return seed + 32'(n);
      2'd1: begin
        s = (seed == 0) ? 32'd1 : seed;
        for (int k = 0; k < n; k++) s = s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
        return s;
      end
      2'd2: return 32'(a);
      default: return ~32'(a);
    endcase
  endfunction

  task automatic build_exp(input logic [AW-1:0] base, input int len, input int nb,
                           input logic [1:0] m, input logic [31:0] seed);
    int L;
    logic [AW-1:0] a;
    L = (len == 0) ? 1 : len;
    exp_log.delete(); exp_err = 0; exp_first = '0;
    for (int b = 0; b < nb; b++)
      for (int i = 0; i < L; i++) begin
        a = (base & ~AW'(3)) + AW'((b * L + i) * 4);
        exp_log.push_back({(i == L - 1) ? 3'b111 : 3'b010, a, exp_word(m, seed, a, b * L + i)});
        if (corrupt.exists(a)) begin
          if (exp_err == 0) exp_first = a;
          exp_err++;
        end
      end
  endtask

  function automatic int first_diff(input ent_t a[$], input ent_t b[$]);
    if (a.size() != b.size()) return -2;
    foreach (a[i]) if (a[i] !== b[i]) return i;
    return -1;
  endfunction

  task automatic run(input logic [AW-1:0] base, input int len, input int nb, input logic [1:0] m,
                     input logic [31:0] seed, output bit ok);
    wr_log.delete(); rd_log.delete();
    build_exp(base, len, nb, m, seed);
    cfg_base_addr = base; cfg_burst_len = BLW'(len); cfg_num_bursts = NBW'(nb);
    cfg_mode = m; cfg_seed = seed;
    @(negedge sys_clk); start = 1'b1;
    @(negedge sys_clk); start = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      if (done) begin ok = 1'b1; break; end
      @(negedge sys_clk);
    end
  endtask

  task automatic test_reset();
    RESETN = 1'b0;
    repeat (3) @(negedge sys_clk);
    n_tests++;
    if ({wb.wb_cyc_o, wb.wb_stb_o, wb.wb_we_o, wb.wb_addr_o, wb.wb_dat_o, wb.wb_cti_o,
         busy, done, err_cnt, first_err_addr, timeout} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got nonzero output(s) err_cnt=%0h busy=%b cyc=%b want all 0",
                         err_cnt, busy, wb.wb_cyc_o);
    end
    RESETN = 1'b1;
    repeat (3) @(negedge sys_clk);
    n_tests++;
    if ({busy, wb.wb_cyc_o} !== 2'b00) begin
      n_fail++; $display("FAIL reset_idle: busy/cyc=%b want 00", {busy, wb.wb_cyc_o});
    end
  endtask

  task automatic test_incr();
    bit ok; int d;
    run(26'h0, 8, 4, 2'd0, 32'h1000, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL t1_done: got no done want done"); end
    d = first_diff(wr_log, exp_log);
    n_tests++; if (d != -1) begin n_fail++; $display("FAIL t1_writes: diff at %0d (n=%0d) want none", d, wr_log.size()); end
    d = first_diff(rd_log, exp_log);
    n_tests++; if (d != -1) begin n_fail++; $display("FAIL t1_reads: diff at %0d (n=%0d) want none", d, rd_log.size()); end
    n_tests++; if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL t1_err: got %0d want 0", err_cnt); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL t1_busy_at_done: got %b want 0", busy); end
    @(negedge sys_clk);
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL t1_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_corrupt();
    bit ok;
    corrupt[26'h24] = 1'b1;
    run(26'h0, 8, 4, 2'd0, 32'h1000, ok);
    n_tests++; if (!ok || err_cnt !== 16'd1) begin n_fail++; $display("FAIL t2_err: got %0d ok=%b want 1", err_cnt, ok); end
    n_tests++; if (first_err_addr !== 26'h24) begin n_fail++; $display("FAIL t2_first: got %0h want 24", first_err_addr); end
    corrupt.delete();
  endtask

  task automatic test_single();
    bit ok; int dw, dr;
    run(26'h340, 0, 1, 2'd2, 32'h0, ok);
    dw = first_diff(wr_log, exp_log);
    dr = first_diff(rd_log, exp_log);
    n_tests++; if (!ok || dw != -1 || dr != -1) begin
      n_fail++; $display("FAIL t3_beat: ok=%b wdiff=%0d rdiff=%0d want 1,-1,-1", ok, dw, dr); end
    n_tests++; if (wr_log.size() != 1 || wr_log[0][3+AW+DW-1 -: 3] !== 3'b111) begin
      n_fail++; $display("FAIL t3_cti: n=%0d want one beat with cti 111", wr_log.size()); end
    n_tests++; if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL t3_err: got %0d want 0", err_cnt); end
  endtask

  task automatic test_wrap();
    bit ok; int d;
    logic [AW-1:0] a8;
    run(26'h3FF_FFF0, 8, 2, 2'd3, 32'h0, ok);
    d = first_diff(rd_log, exp_log);
    n_tests++; if (!ok || d != -1 || first_diff(wr_log, exp_log) != -1) begin
      n_fail++; $display("FAIL t4_list: ok=%b rdiff=%0d want 1,-1", ok, d); end
    a8 = (wr_log.size() > 8) ? wr_log[8][AW+DW-1 -: AW] : '1;
    n_tests++; if (a8 !== 26'h10) begin n_fail++; $display("FAIL t4_wrap_addr: got %0h want 10", a8); end
    n_tests++; if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL t4_err: got %0d want 0", err_cnt); end
  endtask

  task automatic test_zero_bursts();
    bit ok;
    run(26'h100, 4, 0, 2'd0, 32'h5, ok);
    n_tests++; if (!ok || wr_log.size() != 0) begin
      n_fail++; $display("FAIL zero_bursts: ok=%b writes=%0d want 1,0", ok, wr_log.size()); end
  endtask

  task automatic test_random();
    bit ok; int len, nb, d;
    logic [AW-1:0] base;
    logic [1:0] m;
    logic [31:0] seed;
    for (int it = 0; it < 6; it++) begin
      len = $urandom_range(0, 31); nb = $urandom_range(1, 4);
      base = AW'($urandom); m = 2'($urandom_range(0, 3));
      seed = (it == 1) ? 32'h0 : $urandom;
      if (it == 1) m = 2'd1;
      corrupt.delete();
      for (int k = 0; k < (it % 3); k++)
        corrupt[(base & ~AW'(3)) + AW'(4 * $urandom_range(0, 3))] = 1'b1;
      run(base, len, nb, m, seed, ok);
      d = first_diff(wr_log, exp_log);
      n_tests++; if (!ok || d != -1 || first_diff(rd_log, exp_log) != -1) begin
        n_fail++; $display("FAIL rand%0d_list: ok=%b wdiff=%0d mode=%0d len=%0d nb=%0d", it, ok, d, m, len, nb); end
      n_tests++; if (err_cnt !== 16'(exp_err) || (exp_err != 0 && first_err_addr !== exp_first)) begin
        n_fail++; $display("FAIL rand%0d_err: got %0d@%0h want %0d@%0h", it, err_cnt, first_err_addr, exp_err, exp_first); end
    end
    corrupt.delete();
  endtask

  task automatic test_restart_reset();
    bit hit;
    logic [AW-1:0] a0;
    corrupt.delete(); corrupt[26'h200] = 1'b1;
    wr_log.delete(); rd_log.delete();
    cfg_base_addr = 26'h200; cfg_burst_len = 5'd8; cfg_num_bursts = 16'd4; cfg_mode = 2'd1; cfg_seed = $urandom;
    @(negedge sys_clk); start = 1'b1;
    @(negedge sys_clk); start = 1'b0;
    repeat (3) @(negedge sys_clk);
    cfg_base_addr = 26'h8000; cfg_burst_len = 5'd2;
    start = 1'b1; @(negedge sys_clk); start = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge sys_clk); #1;
      if (rd_log.size() == 3) begin hit = 1'b1; break; end
    end
    n_tests++; if (!hit) begin n_fail++; $display("FAIL t5_third_read: not reached want reached"); end
    a0 = (wr_log.size() > 0) ? wr_log[0][AW+DW-1 -: AW] : '1;
    n_tests++; if (a0 !== 26'h200 || wr_log.size() != 8) begin
      n_fail++; $display("FAIL t5_restart_ignored: addr0=%0h writes=%0d want 200,8", a0, wr_log.size()); end
    n_tests++; if (err_cnt !== 16'd1) begin n_fail++; $display("FAIL t5_err_before: got %0d want 1", err_cnt); end
    RESETN = 1'b0; #1;
    n_tests++; if ({wb.wb_cyc_o, wb.wb_stb_o, busy} !== 3'b000 || err_cnt !== 16'd0) begin
      n_fail++; $display("FAIL t5_async_reset: cyc/stb/busy=%b err=%0d want 000,0",
                         {wb.wb_cyc_o, wb.wb_stb_o, busy}, err_cnt); end
    stb_cyc = 0;
    repeat (4) @(negedge sys_clk);
    RESETN = 1'b1;
    repeat (4) @(negedge sys_clk);
    n_tests++; if (stb_cyc != 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL t5_quiet: stb cycles=%0d busy=%b want 0,0", stb_cyc, busy); end
    corrupt.delete();
  endtask

  task automatic test_timeout();
    bit ok;
    ack_en = 1'b0;
    cfg_base_addr = 26'h40; cfg_burst_len = 5'd4; cfg_num_bursts = 16'd1; cfg_mode = 2'd0;
    stb_cyc = 0;
    @(negedge sys_clk); start = 1'b1;
    @(negedge sys_clk); start = 1'b0;
`ifdef TG_TIMEOUT_EN
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (done) begin ok = 1'b1; break; end
      @(negedge sys_clk);
    end
    n_tests++; if (!ok || stb_cyc != TOC) begin
      n_fail++; $display("FAIL t6_stb_cycles: ok=%b got %0d want %0d", ok, stb_cyc, TOC); end
    n_tests++; if (timeout !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL t6_timeout: timeout=%b busy=%b want 1,0", timeout, busy); end
    @(negedge sys_clk);
    n_tests++; if (timeout !== 1'b1 || wb.wb_stb_o !== 1'b0) begin
      n_fail++; $display("FAIL t6_hold: timeout=%b stb=%b want 1,0", timeout, wb.wb_stb_o); end
`else
    ok = 1'b0;
    repeat (100) @(negedge sys_clk);
    n_tests++; if (busy !== 1'b1 || wb.wb_stb_o !== 1'b1 || timeout !== 1'b0) begin
      n_fail++; $display("FAIL t6_no_watchdog: busy=%b stb=%b timeout=%b want 1,1,0", busy, wb.wb_stb_o, timeout); end
    RESETN = 1'b0; repeat (2) @(negedge sys_clk); RESETN = 1'b1;
    @(negedge sys_clk);
    n_tests++; if (busy !== 1'b0 || ok) begin n_fail++; $display("FAIL t6_recover: busy=%b want 0", busy); end
`endif
    ack_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_incr();
    test_corrupt();
    test_single();
    test_wrap();
    test_zero_bursts();
    test_random();
    test_restart_reset();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
